data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder side of the load/store unit's memory request interface. Accepts one request per transaction: the address, read/write flag, byte-lane select and sign-extend flag produced by the address-generation stage, plus store data. Performs the access on an internal word-wide data RAM after a programmable number of wait states, then returns aligned, extended load data and a misalignment flag to the writeback side. It sits between the load/store issue slot and writeback/commit.

## Interface

- `ADDR_W`, default 10: word-index width; RAM holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 1: wait states per access, legal range 0..7.

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request
- `Address`  in  32  byte address
- `RW`  in  1  0 = load, 1 = store
- `Sel`  in  4  lane select: 0001 byte, 0011 halfword, 1111 word, 0000 no access
- `Signed_Extend`  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- `Wdata`  in  32  store data, right-justified
- `rsp_valid`  out  1  one-cycle response strobe
- `Rdata`  out  32  load result; 0 for stores, faults and no-access requests
- `misalign`  out  1  request faulted; valid with `rsp_valid`

## Operation

- FSM states: IDLE, WAIT, RESP. `req_ready` = 1 only in IDLE.
- IDLE: if `req_valid` is 1, latch `Address`, `RW`, `Sel`, `Signed_Extend` and `Wdata` at that edge (accept edge). Go to WAIT with counter = `WAIT_CYCLES`, or go straight to RESP if `WAIT_CYCLES` = 0.
- WAIT: decrement the counter each cycle. At the edge where the counter is 1, go to RESP.
- RESP: `rsp_valid` = 1 for exactly this cycle. Next state is IDLE unconditionally. The consumer cannot backpressure the response.
- Memory access happens on the edge that enters RESP. Store write and `Rdata`/`misalign` registration share that edge.
- Word index is `Address[ADDR_W+1:2]`. Higher address bits are ignored, so addresses alias.
- Byte order is little-endian. Lane n = bits [8n+7:8n]. Byte lane = `Address[1:0]`. Half lanes = {`Address[1]`,0} and {`Address[1]`,1}.
- Fault check:
  - Halfword fault: `Address[0]` = 1.
  - Word fault: `Address[1:0]` ≠ 0.
  - Any `Sel` outside {0000, 0001, 0011, 1111} is also a fault.
  - On a fault: `misalign` = 1, `Rdata` = 0, no RAM write.
- Store: write only the selected lanes with `Wdata[7:0]`, `Wdata[15:0]` or `Wdata[31:0]`. Other lanes are untouched. `Signed_Extend` is ignored.
- Load byte/half: extract the lane(s) and right-justify. Fill the upper bits with the sign bit when `Signed_Extend` = 1, else with 0. Word load returns the word unchanged.
- `Sel` = 0000: no RAM access, `Rdata` = 0, `misalign` = 0, normal response timing.
- RAM contents are not reset. A read of an unwritten word is X, and benches must not check it.

## Timing

- Reset (async assert, sync deassert seen at next edge):
  - state = IDLE, counter = 0
  - `req_ready` = 1
  - `rsp_valid` = 0
  - `Rdata` = 0x00000000
  - `misalign` = 0
- Latency: with accept edge E, `rsp_valid` is high in the cycle after edge E+`WAIT_CYCLES`+1 − 1. Equivalently, high for the one cycle following the (`WAIT_CYCLES`+1)-th edge counting E as the first.
  - `WAIT_CYCLES` = 0: response in the cycle right after acceptance.
- Throughput: one transaction per `WAIT_CYCLES`+2 cycles. `req_ready` returns to 1 in the cycle after RESP.
- `Rdata` and `misalign` hold their values after RESP until the next response. Consumers qualify them with `rsp_valid`.
- Request inputs are sampled only at the accept edge. Changes while not in IDLE are ignored.
- Reset mid-transaction:
  - Asserted in WAIT: the pending store is dropped and no response is issued.
  - Asserted in RESP: a write already committed on the RESP-entry edge stays committed.

## Test plan

- Store word 0x8899AABB at 0x100, then load word from 0x100 → `Rdata` = 0x8899AABB, `misalign` = 0. `rsp_valid` arrives exactly `WAIT_CYCLES`+1 edges after each accept; repeat with `WAIT_CYCLES` = 0 and 3.
- After the word above, store byte 0x5A at 0x102, then:
  - load word 0x100 → 0x885AAABB
  - signed byte load 0x103 → 0xFFFFFF88
  - unsigned byte load 0x103 → 0x00000088
- Store half 0x8001 at 0x106, then:
  - signed half load 0x106 → 0xFFFF8001
  - unsigned half load → 0x00008001
  - lanes 0..1 of word 0x104 unchanged
- Misalignment cases, each → `misalign` = 1, `Rdata` = 0, RAM word unchanged on readback:
  - half store at 0x101
  - word load at 0x102
  - `Sel` = 0010
- Hold `req_valid` high continuously → `req_ready` pulses once per `WAIT_CYCLES`+2 cycles and each request gets exactly one `rsp_valid`. `Sel` = 0000 → response with `Rdata` = 0, `misalign` = 0.
- Assert `rst_n` low during WAIT of a store to 0x200 whose prior content is 0x11111111 → `rsp_valid` never asserts, outputs at reset values; a later load of 0x200 → 0x11111111.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Load/store request and response bus between the issue slot (master)
// and the data memory responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] Address;
    logic        RW;
    logic [3:0]  Sel;
    logic        Signed_Extend;
    logic [31:0] Wdata;
    logic        rsp_valid;
    logic [31:0] Rdata;
    logic        misalign;

    modport master (
        output req_valid, Address, RW, Sel, Signed_Extend, Wdata,
        input  req_ready, rsp_valid, Rdata, misalign
    );

    modport slave (
        input  req_valid, Address, RW, Sel, Signed_Extend, Wdata,
        output req_ready, rsp_valid, Rdata, misalign
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: one load/store per transaction on a word-wide RAM,
// with programmable wait states, lane alignment, extension and fault detection.
module data_mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        addr_q;
    logic               rw_q;
    logic [3:0]         sel_q;
    logic               sext_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               misalign_q;

    logic [DATA_W-1:0]  mem [DEPTH];

    // Access operands: live bus while idle (zero-wait path), latched copy otherwise.
    logic               in_idle_c;
    logic [31:0]        cur_addr_c;
    logic               cur_rw_c;
    logic [3:0]         cur_sel_c;
    logic               cur_sext_c;
    logic [DATA_W-1:0]  cur_wdata_c;

    assign in_idle_c   = (state_q == S_IDLE);
    assign cur_addr_c  = in_idle_c ? bus.Address       : addr_q;
    assign cur_rw_c    = in_idle_c ? bus.RW            : rw_q;
    assign cur_sel_c   = in_idle_c ? bus.Sel           : sel_q;
    assign cur_sext_c  = in_idle_c ? bus.Signed_Extend : sext_q;
    assign cur_wdata_c = in_idle_c ? bus.Wdata         : wdata_q;

    logic [ADDR_W-1:0]  idx_c;
    logic [1:0]         lane_c;
    logic               enter_resp_c;
    logic               do_write_c;

    assign idx_c  = cur_addr_c[ADDR_W+1:2];
    assign lane_c = cur_addr_c[1:0];

    assign enter_resp_c = (in_idle_c && bus.req_valid && ZERO_WAIT) ||
                          (state_q == S_WAIT && cnt_q == CNT_W'(1));

    if (ADDR_W + 2 < 32) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^cur_addr_c[31:ADDR_W+2];
    end

    // Lane decode, fault detection, store lane enables and load extraction.
    logic               sel_legal_c;
    logic               fault_c;
    logic [3:0]         be_c;
    logic [DATA_W-1:0]  wword_c;
    logic [DATA_W-1:0]  rword_c;
    logic [DATA_W-1:0]  shifted_c;
    logic [DATA_W-1:0]  load_c;

    always_comb begin
        sel_legal_c = 1'b0;
        fault_c     = 1'b0;
        be_c        = 4'b0000;
        wword_c     = '0;
        load_c      = '0;
        rword_c     = mem[idx_c];
        shifted_c   = rword_c >> {lane_c, 3'b000};
        case (cur_sel_c)
            4'b0000: sel_legal_c = 1'b1;
            4'b0001: begin
                sel_legal_c = 1'b1;
                be_c        = 4'(4'b0001 << lane_c);
                wword_c     = {4{cur_wdata_c[7:0]}};
                load_c      = {{24{cur_sext_c & shifted_c[7]}}, shifted_c[7:0]};
            end
            4'b0011: begin
                sel_legal_c = 1'b1;
                fault_c     = lane_c[0];
                be_c        = lane_c[1] ? 4'b1100 : 4'b0011;
                wword_c     = {2{cur_wdata_c[15:0]}};
                load_c      = {{16{cur_sext_c & shifted_c[15]}}, shifted_c[15:0]};
            end
            4'b1111: begin
                sel_legal_c = 1'b1;
                fault_c     = (lane_c != 2'b00);
                be_c        = 4'b1111;
                wword_c     = cur_wdata_c;
                load_c      = rword_c;
            end
            default: sel_legal_c = 1'b0;
        endcase
        if (!sel_legal_c) begin
            fault_c = 1'b1;
        end
    end

    // No RAM commit can sneak in while reset is held.
    assign do_write_c = enter_resp_c && rst_n && cur_rw_c && !fault_c;

    // Data RAM: contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write_c) begin
            for (int n = 0; n < 4; n++) begin
                if (be_c[n]) begin
                    mem[idx_c][8*n +: 8] <= wword_c[8*n +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            sel_q       <= 4'b0000;
            sext_q      <= 1'b0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (enter_resp_c) begin
                rsp_valid_q <= 1'b1;
                misalign_q  <= fault_c;
                rdata_q     <= (fault_c || cur_rw_c) ? '0 : load_c;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.Address;
                        rw_q        <= bus.RW;
                        sel_q       <= bus.Sel;
                        sext_q      <= bus.Signed_Extend;
                        wdata_q     <= bus.Wdata;
                        req_ready_q <= 1'b0;
                        if (ZERO_WAIT) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.Rdata     = rdata_q;
    assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 1 and 3 wait states) share
// one stimulus stream and are checked against a byte-level memory model.
module tb_data_mem_responder;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned WORDS  = 1 << ADDR_W;
    localparam int          NDUT   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a [NDUT];
    logic        req_valid;
    logic [31:0] addr;
    logic        rw;
    logic [3:0]  sel;
    logic        sext;
    logic [31:0] wdata;

    logic        ready_v [NDUT];
    logic        rsp_v   [NDUT];
    logic [31:0] rd_v    [NDUT];
    logic        mis_v   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_mem_responder_if bus ();
        assign bus.req_valid     = req_valid;
        assign bus.Address       = addr;
        assign bus.RW            = rw;
        assign bus.Sel           = sel;
        assign bus.Signed_Extend = sext;
        assign bus.Wdata         = wdata;
        assign ready_v[g]        = bus.req_ready;
        assign rsp_v[g]          = bus.rsp_valid;
        assign rd_v[g]           = bus.Rdata;
        assign mis_v[g]          = bus.misalign;
        data_mem_responder #(
            .ADDR_W      (ADDR_W),
            .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n_a[g]),
            .bus   (bus)
        );
    end

    int checks   = 0;
    int failures = 0;

    // Reference memory per instance, with per-byte written flags.
    logic [31:0] mem_m     [NDUT][WORDS];
    bit          written_m [NDUT][WORDS][4];

    logic [31:0] obs_rd  [NDUT];
    logic        obs_mis [NDUT];

    typedef struct {
        logic        w;
        logic [3:0]  s;
        logic        se;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
    } step_t;

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic void model_op(input int d, input logic w, input logic [3:0] s,
                                     input logic se, input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] exp_rd, output logic exp_mis,
                                     output bit known);
        int idx;
        int lo;
        int nbytes;
        logic [31:0] v;
        idx     = int'(a[ADDR_W+1:2]);
        lo      = int'(a[1:0]);
        exp_rd  = 32'h0;
        exp_mis = 1'b0;
        known   = 1'b1;
        v       = 32'h0;
        case (s)
            4'b0000: nbytes = 0;
            4'b0001: nbytes = 1;
            4'b0011: nbytes = 2;
            4'b1111: nbytes = 4;
            default: nbytes = -1;
        endcase
        if (nbytes < 0 || (nbytes > 0 && (lo % nbytes) != 0)) begin
            exp_mis = 1'b1;
            return;
        end
        if (nbytes == 0) return;
        if (w) begin
            for (int k = 0; k < nbytes; k++) begin
                mem_m[d][idx][8*(lo+k) +: 8] = wd[8*k +: 8];
                written_m[d][idx][lo+k]      = 1'b1;
            end
        end else begin
            for (int k = 0; k < nbytes; k++) begin
                if (!written_m[d][idx][lo+k]) known = 1'b0;
                v[8*k +: 8] = mem_m[d][idx][8*(lo+k) +: 8];
            end
            if (se && v[8*nbytes-1]) begin
                for (int k = nbytes; k < 4; k++) v[8*k +: 8] = 8'hFF;
            end
            exp_rd = v;
        end
    endfunction

    // One request broadcast to all instances; each response checked for latency and data.
    task automatic do_txn(input logic w, input logic [3:0] s, input logic se,
                          input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] e_rd    [NDUT];
        logic        e_mis   [NDUT];
        bit          e_known [NDUT];
        int          first_k [NDUT];
        int          pulses  [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            model_op(d, w, s, se, a, wd, e_rd[d], e_mis[d], e_known[d]);
            first_k[d] = -1;
            pulses[d]  = 0;
            obs_rd[d]  = 'x;
            obs_mis[d] = 1'bx;
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ready_v[d] !== 1'b1) begin
                failures++;
                $display("FAIL txn_ready_idle dut%0d got=%b want=1", d, ready_v[d]);
            end
        end
        req_valid = 1'b1; rw = w; sel = s; sext = se; addr = a; wdata = wd;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                rw = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
                for (int d = 0; d < NDUT; d++) begin
                    checks++;
                    if (ready_v[d] !== 1'b0) begin
                        failures++;
                        $display("FAIL txn_ready_busy dut%0d got=%b want=0", d, ready_v[d]);
                    end
                end
            end
            for (int d = 0; d < NDUT; d++) begin
                if (rsp_v[d] === 1'b1) begin
                    pulses[d]++;
                    if (first_k[d] < 0) first_k[d] = k;
                    obs_rd[d]  = rd_v[d];
                    obs_mis[d] = mis_v[d];
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (pulses[d] != 1 || first_k[d] != wait_of(d) + 1) begin
                failures++;
                $display("FAIL txn_latency dut%0d a=%h got pulses=%0d edge=%0d want pulses=1 edge=%0d",
                         d, a, pulses[d], first_k[d], wait_of(d) + 1);
            end
            checks++;
            if (obs_mis[d] !== e_mis[d]) begin
                failures++;
                $display("FAIL txn_misalign dut%0d a=%h sel=%b got=%b want=%b", d, a, s, obs_mis[d], e_mis[d]);
            end
            if (e_known[d]) begin
                checks++;
                if (obs_rd[d] !== e_rd[d]) begin
                    failures++;
                    $display("FAIL txn_rdata dut%0d rw=%b a=%h sel=%b se=%b got=%h want=%h",
                             d, w, a, s, se, obs_rd[d], e_rd[d]);
                end
            end
        end
    endtask

    task automatic test_reset;
        req_valid = 1'b0; rw = 1'b0; sel = 4'b0000; sext = 1'b0; addr = '0; wdata = '0;
        for (int d = 0; d < NDUT; d++) rst_n_a[d] = 1'b0;
        repeat (3) @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (ready_v[d] !== 1'b1 || rsp_v[d] !== 1'b0 || rd_v[d] !== 32'h0 || mis_v[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_values dut%0d pass%0d got ready=%b rsp=%b rd=%h mis=%b want 1 0 00000000 0",
                             d, pass, ready_v[d], rsp_v[d], rd_v[d], mis_v[d]);
                end
            end
            for (int d = 0; d < NDUT; d++) rst_n_a[d] = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_store_load;
        step_t tbl [$];
        tbl.push_back(step_t'{1'b1, 4'hF, 1'b0, 32'h0000_0100, 32'h8899AABB, 32'h0000_0000, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'hF, 1'b0, 32'h0000_0100, 32'h0,        32'h8899AABB, 1'b0});
        tbl.push_back(step_t'{1'b1, 4'h1, 1'b1, 32'h0000_0102, 32'hFFFF_FF5A, 32'h0000_0000, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'hF, 1'b0, 32'h0000_0100, 32'h0,        32'h885AAABB, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'h1, 1'b1, 32'h0000_0103, 32'h0,        32'hFFFFFF88, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'h1, 1'b0, 32'h0000_0103, 32'h0,        32'h00000088, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'h1, 1'b1, 32'h0000_0102, 32'h0,        32'h0000005A, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'h1, 1'b1, 32'h0000_0100, 32'h0,        32'hFFFFFFBB, 1'b0});
        tbl.push_back(step_t'{1'b1, 4'hF, 1'b0, 32'h0000_0104, 32'h12345678, 32'h0000_0000, 1'b0});
        tbl.push_back(step_t'{1'b1, 4'h3, 1'b0, 32'h0000_0106, 32'hABCD_8001, 32'h0000_0000, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'h3, 1'b1, 32'h0000_0106, 32'h0,        32'hFFFF8001, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'h3, 1'b0, 32'h0000_0106, 32'h0,        32'h00008001, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'hF, 1'b0, 32'h0000_0104, 32'h0,        32'h80015678, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'hF, 1'b0, 32'hABCD_E104, 32'h0,        32'h80015678, 1'b0});
        foreach (tbl[i]) begin
            do_txn(tbl[i].w, tbl[i].s, tbl[i].se, tbl[i].a, tbl[i].wd);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (obs_rd[d] !== tbl[i].rd || obs_mis[d] !== tbl[i].mis) begin
                    failures++;
                    $display("FAIL store_load step%0d dut%0d got rd=%h mis=%b want rd=%h mis=%b",
                             i, d, obs_rd[d], obs_mis[d], tbl[i].rd, tbl[i].mis);
                end
            end
        end
    endtask

    task automatic test_misalign;
        step_t tbl [$];
        tbl.push_back(step_t'{1'b1, 4'h3, 1'b0, 32'h0000_0101, 32'h0000_FFFF, 32'h0000_0000, 1'b1});
        tbl.push_back(step_t'{1'b0, 4'hF, 1'b0, 32'h0000_0100, 32'h0,        32'h885AAABB, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'hF, 1'b0, 32'h0000_0102, 32'h0,        32'h0000_0000, 1'b1});
        tbl.push_back(step_t'{1'b0, 4'h3, 1'b1, 32'h0000_0103, 32'h0,        32'h0000_0000, 1'b1});
        tbl.push_back(step_t'{1'b1, 4'h2, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        tbl.push_back(step_t'{1'b1, 4'hF, 1'b0, 32'h0000_0101, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        tbl.push_back(step_t'{1'b0, 4'hF, 1'b0, 32'h0000_0100, 32'h0,        32'h885AAABB, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'h0, 1'b1, 32'h0000_0100, 32'h0,        32'h0000_0000, 1'b0});
        tbl.push_back(step_t'{1'b1, 4'h0, 1'b0, 32'h0000_0104, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        tbl.push_back(step_t'{1'b0, 4'hF, 1'b0, 32'h0000_0104, 32'h0,        32'h80015678, 1'b0});
        foreach (tbl[i]) begin
            do_txn(tbl[i].w, tbl[i].s, tbl[i].se, tbl[i].a, tbl[i].wd);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (obs_rd[d] !== tbl[i].rd || obs_mis[d] !== tbl[i].mis) begin
                    failures++;
                    $display("FAIL misalign step%0d dut%0d got rd=%h mis=%b want rd=%h mis=%b",
                             i, d, obs_rd[d], obs_mis[d], tbl[i].rd, tbl[i].mis);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc [NDUT];
        int rsp [NDUT];
        int last [NDUT];
        int gap_bad [NDUT];
        int data_bad [NDUT];
        int ncyc;
        ncyc = 60;
        for (int d = 0; d < NDUT; d++) begin
            acc[d] = 0; rsp[d] = 0; last[d] = -1; gap_bad[d] = 0; data_bad[d] = 0;
        end
        @(negedge clk);
        req_valid = 1'b1; rw = 1'b0; sel = 4'b0000; sext = 1'b1; addr = $urandom; wdata = $urandom;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int d = 0; d < NDUT; d++) begin
                if (ready_v[d] === 1'b1) begin
                    acc[d]++;
                    if (last[d] >= 0 && cyc - last[d] != wait_of(d) + 2) gap_bad[d]++;
                    last[d] = cyc;
                end
            end
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (rsp_v[d] === 1'b1) begin
                    rsp[d]++;
                    if (rd_v[d] !== 32'h0 || mis_v[d] !== 1'b0) data_bad[d]++;
                end
            end
        end
        req_valid = 1'b0;
        repeat (8) begin
            for (int d = 0; d < NDUT; d++) if (rsp_v[d] === 1'b1) rsp[d]++;
            @(negedge clk);
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (acc[d] != (ncyc - 1) / (wait_of(d) + 2) + 1 || gap_bad[d] != 0) begin
                failures++;
                $display("FAIL b2b_accepts dut%0d got=%0d gaps_off=%0d want=%0d gaps_off=0",
                         d, acc[d], gap_bad[d], (ncyc - 1) / (wait_of(d) + 2) + 1);
            end
            checks++;
            if (rsp[d] != acc[d] || data_bad[d] != 0) begin
                failures++;
                $display("FAIL b2b_responses dut%0d got=%0d bad_data=%0d want=%0d bad_data=0",
                         d, rsp[d], data_bad[d], acc[d]);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] e_rd;
        logic        e_mis;
        bit          e_known;
        int          stray;
        do_txn(1'b1, 4'hF, 1'b0, 32'h0000_0200, 32'h11111111);
        @(negedge clk);
        req_valid = 1'b1; rw = 1'b1; sel = 4'hF; sext = 1'b0; addr = 32'h0000_0200; wdata = 32'hDEADBEEF;
        @(posedge clk);
        #2;
        for (int d = 0; d < NDUT; d++) rst_n_a[d] = 1'b0;
        req_valid = 1'b0;
        // Zero-wait instance already committed on the accept edge.
        model_op(0, 1'b1, 4'hF, 1'b0, 32'h0000_0200, 32'hDEADBEEF, e_rd, e_mis, e_known);
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (ready_v[d] !== 1'b1 || rsp_v[d] !== 1'b0 || rd_v[d] !== 32'h0 || mis_v[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_wait_values dut%0d got ready=%b rsp=%b rd=%h mis=%b want 1 0 00000000 0",
                             d, ready_v[d], rsp_v[d], rd_v[d], mis_v[d]);
                end
            end
        end
        for (int d = 0; d < NDUT; d++) rst_n_a[d] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) if (rsp_v[d] !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL rst_wait_no_rsp got=%0d want=0", stray);
        end
        do_txn(1'b0, 4'hF, 1'b0, 32'h0000_0200, 32'h0);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (obs_rd[d] !== ((d == 0) ? 32'hDEADBEEF : 32'h11111111)) begin
                failures++;
                $display("FAIL rst_wait_readback dut%0d got=%h want=%h",
                         d, obs_rd[d], (d == 0) ? 32'hDEADBEEF : 32'h11111111);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [3:0]  s;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            a[11:0] = 12'h300 + 12'(i * 4);
            do_txn(1'b1, 4'hF, 1'b0, a, $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            a[11:2] = 10'h0C0 + 10'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0:       s = 4'b0000;
                1:       s = 4'b0001;
                2:       s = 4'b0011;
                3:       s = 4'b1111;
                default: s = 4'($urandom);
            endcase
            do_txn(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misalign();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
